// File: rtl/aes_key_ctrl_if.sv
// Control/status bundle between the AES top FSM, key register file and aes_key_ctrl.
interface aes_key_ctrl_if;
    logic       StartxSI;
    logic       KeyValidxSI;
    logic       KeyReadyxSO;
    logic       KeyRegEnxSO;
    logic       KeySchedulexSO;
    logic       ForthCyclexSO;
    logic       RconAddxSO;
    logic [7:0] RconxDO;
    logic [3:0] RoundxDO;
    logic       BusyxSO;
    logic       DonexSO;

    // Controller side
    modport slave (
        input  StartxSI,
        input  KeyValidxSI,
        output KeyReadyxSO,
        output KeyRegEnxSO,
        output KeySchedulexSO,
        output ForthCyclexSO,
        output RconAddxSO,
        output RconxDO,
        output RoundxDO,
        output BusyxSO,
        output DonexSO
    );

    // Requester / observer side
    modport master (
        output StartxSI,
        output KeyValidxSI,
        input  KeyReadyxSO,
        input  KeyRegEnxSO,
        input  KeySchedulexSO,
        input  ForthCyclexSO,
        input  RconAddxSO,
        input  RconxDO,
        input  RoundxDO,
        input  BusyxSO,
        input  DonexSO
    );
endinterface

// File: rtl/aes_key_ctrl.sv
// Byte-serial AES-128 key register sequencer: 16-byte key load, then NR
// 16-cycle round frames driving shift enable, rotate select, RotWord tap and Rcon.
module aes_key_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic           ClkxCI,
    input  logic           RstxRI,
    aes_key_ctrl_if.slave  kif
);

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ROUND_W = 4;
    localparam int unsigned RCON_W  = 8;

    localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(15);
    localparam logic [ROUND_W-1:0] LAST_RND  = ROUND_W'(NR);
    localparam logic [RCON_W-1:0]  RCON_INIT = RCON_W'(8'h01);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e               state_q,    state_d;
    logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
    logic [ROUND_W-1:0]   round_q,    round_d;
    logic [RCON_W-1:0]    rcon_q,     rcon_d;
    logic [RCON_W-1:0]    rcon_xtime;

    // GF(2^8) doubling of the round constant
    always_comb begin
        rcon_xtime = {rcon_q[RCON_W-2:0], 1'b0} ^ (rcon_q[RCON_W-1] ? RCON_W'(8'h1B) : RCON_W'(8'h00));
    end

    // Next-state, byte counter, round and Rcon update
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        round_d    = round_q;
        rcon_d     = rcon_q;
        unique case (state_q)
            IDLE: begin
                if (kif.StartxSI) begin
                    state_d    = LOAD;
                    byte_cnt_d = '0;
                end
            end
            LOAD: begin
                // ready is constant high here, so valid alone marks an accept
                if (kif.KeyValidxSI) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d    = ROUND;
                        round_d    = ROUND_W'(1);
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
            end
            ROUND: begin
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                if (byte_cnt_q == LAST_BYTE) begin
                    if (round_q == LAST_RND) begin
                        state_d = DONE;
                    end else begin
                        round_d = round_q + ROUND_W'(1);
                        rcon_d  = rcon_xtime;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                byte_cnt_d = '0;
                round_d    = '0;
                rcon_d     = RCON_INIT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge ClkxCI) begin
        if (RstxRI) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            round_q    <= '0;
            rcon_q     <= RCON_INIT;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            round_q    <= round_d;
            rcon_q     <= rcon_d;
        end
    end

    // Output decode from registered state; only the LOAD shift enable sees an input
    always_comb begin
        kif.KeyReadyxSO    = (state_q == LOAD);
        kif.KeyRegEnxSO    = ((state_q == LOAD) && kif.KeyValidxSI) || (state_q == ROUND);
        kif.KeySchedulexSO = (state_q == ROUND) && (byte_cnt_q[3:2] == 2'b11);
        kif.ForthCyclexSO  = (state_q == ROUND) && (byte_cnt_q == CNT_W'(3));
        kif.RconAddxSO     = (state_q == ROUND) && (byte_cnt_q == CNT_W'(0));
        kif.RconxDO        = rcon_q;
        kif.RoundxDO       = round_q;
        kif.BusyxSO        = (state_q == LOAD) || (state_q == ROUND);
        kif.DonexSO        = (state_q == DONE);
    end

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Directed bench for aes_key_ctrl: default NR=10 instance plus an NR=1 instance.
module tb_aes_key_ctrl;

    logic clk;
    logic rst;

    aes_key_ctrl_if ifa ();
    aes_key_ctrl_if ifb ();

    aes_key_ctrl #(.NR(10)) u_dut_a (.ClkxCI(clk), .RstxRI(rst), .kif(ifa));
    aes_key_ctrl #(.NR(1))  u_dut_b (.ClkxCI(clk), .RstxRI(rst), .kif(ifb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0] rc_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};

    // One comparison, counted and reported on failure
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample 1 time unit after the rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle/reset output image of the NR=10 instance
    task automatic chk_idle_a(input string tag);
        chk({tag, "_ready"}, 32'(ifa.KeyReadyxSO),    32'd0);
        chk({tag, "_regen"}, 32'(ifa.KeyRegEnxSO),    32'd0);
        chk({tag, "_sched"}, 32'(ifa.KeySchedulexSO), 32'd0);
        chk({tag, "_forth"}, 32'(ifa.ForthCyclexSO),  32'd0);
        chk({tag, "_radd"},  32'(ifa.RconAddxSO),     32'd0);
        chk({tag, "_rcon"},  32'(ifa.RconxDO),        32'h01);
        chk({tag, "_round"}, 32'(ifa.RoundxDO),       32'd0);
        chk({tag, "_busy"},  32'(ifa.BusyxSO),        32'd0);
        chk({tag, "_done"},  32'(ifa.DonexSO),        32'd0);
    endtask

    // Step until DonexSO of the NR=10 instance, bounded
    task automatic wait_done_a(inout int cyc);
        while (!ifa.DonexSO && cyc < 1000) begin
            step();
            cyc++;
        end
    endtask

    initial begin
        int cyc;
        int acc;
        int gaps;
        int i;
        int n_radd;
        int n_forth;

        rst = 1'b1;
        ifa.StartxSI = 1'b0; ifa.KeyValidxSI = 1'b0;
        ifb.StartxSI = 1'b0; ifb.KeyValidxSI = 1'b0;
        step();
        step();
        chk_idle_a("reset");
        chk("reset_b_rcon", 32'(ifb.RconxDO), 32'h01);
        chk("reset_b_busy", 32'(ifb.BusyxSO), 32'd0);
        rst = 1'b0;
        step();
        chk_idle_a("idle");

        // Full default run with key bytes always valid
        ifa.StartxSI = 1'b1; ifa.KeyValidxSI = 1'b1;
        cyc = 1;
        step(); cyc++;
        ifa.StartxSI = 1'b0;
        chk("busy_rise", 32'(ifa.BusyxSO), 32'd1);
        for (int k = 0; k < 16; k++) begin
            chk("load_ready", 32'(ifa.KeyReadyxSO), 32'd1);
            chk("load_round", 32'(ifa.RoundxDO), 32'd0);
            step(); cyc++;
        end
        chk("ready_after_load", 32'(ifa.KeyReadyxSO), 32'd0);
        for (int r = 1; r <= 10; r++) begin
            for (int off = 0; off < 16; off++) begin
                if (off == 0) begin
                    chk("rcon_seq",  32'(ifa.RconxDO),  32'(rc_tab[r-1]));
                    chk("round_idx", 32'(ifa.RoundxDO), 32'(r));
                end
                chk("rnd_forth", 32'(ifa.ForthCyclexSO),  32'(off == 3));
                chk("rnd_radd",  32'(ifa.RconAddxSO),     32'(off == 0));
                chk("rnd_sched", 32'(ifa.KeySchedulexSO), 32'(off >= 12));
                chk("rnd_regen", 32'(ifa.KeyRegEnxSO),    32'd1);
                chk("rnd_busy",  32'(ifa.BusyxSO),        32'd1);
                chk("rnd_done",  32'(ifa.DonexSO),        32'd0);
                step(); cyc++;
            end
        end
        chk("done_pulse",   32'(ifa.DonexSO),     32'd1);
        chk("done_latency", 32'(cyc),             32'd178);
        chk("done_busy",    32'(ifa.BusyxSO),     32'd0);
        chk("done_regen",   32'(ifa.KeyRegEnxSO), 32'd0);
        ifa.KeyValidxSI = 1'b0;
        step();
        chk_idle_a("post_done");

        // Load with valid gaps (1,0,0 pattern), Start held high throughout
        ifa.StartxSI = 1'b1; ifa.KeyValidxSI = 1'b0;
        cyc = 1;
        step(); cyc++;
        acc = 0; gaps = 0; i = 0;
        while (acc < 16 && i < 200) begin
            ifa.KeyValidxSI = ((i % 3) == 0);
            #1;
            chk("gap_regen", 32'(ifa.KeyRegEnxSO), 32'(ifa.KeyValidxSI));
            chk("gap_ready", 32'(ifa.KeyReadyxSO), 32'd1);
            if (ifa.KeyValidxSI) acc++; else gaps++;
            i++;
            step(); cyc++;
        end
        ifa.KeyValidxSI = 1'b1;
        chk("gap_enter_round", 32'(ifa.RoundxDO),    32'd1);
        chk("gap_ready_off",   32'(ifa.KeyReadyxSO), 32'd0);
        wait_done_a(cyc);
        chk("gap_latency", 32'(cyc), 32'(178 + gaps));
        ifa.StartxSI = 1'b0;
        step();
        chk_idle_a("gap_idle");

        // Reset asserted in round 5 at byte 7
        ifa.StartxSI = 1'b1; ifa.KeyValidxSI = 1'b1;
        step();
        ifa.StartxSI = 1'b0;
        repeat (16 + 64 + 7) step();
        chk("mid_round", 32'(ifa.RoundxDO), 32'd5);
        chk("mid_rcon",  32'(ifa.RconxDO),  32'h10);
        chk("mid_sched", 32'(ifa.KeySchedulexSO), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ifa.KeyValidxSI = 1'b0;
        chk_idle_a("midrst");
        ifa.StartxSI = 1'b1; ifa.KeyValidxSI = 1'b1;
        cyc = 1;
        step(); cyc++;
        ifa.StartxSI = 1'b0;
        wait_done_a(cyc);
        chk("rerun_latency", 32'(cyc), 32'd178);
        step();
        chk_idle_a("rerun_idle");

        // Start held continuously: back-to-back runs with one IDLE cycle
        ifa.StartxSI = 1'b1; ifa.KeyValidxSI = 1'b1;
        cyc = 1;
        step(); cyc++;
        wait_done_a(cyc);
        chk("b2b_latency1", 32'(cyc), 32'd178);
        step();
        chk("b2b_idle_busy",  32'(ifa.BusyxSO),     32'd0);
        chk("b2b_idle_ready", 32'(ifa.KeyReadyxSO), 32'd0);
        chk("b2b_idle_done",  32'(ifa.DonexSO),     32'd0);
        cyc = 1;
        step(); cyc++;
        chk("b2b_load_busy",  32'(ifa.BusyxSO),     32'd1);
        chk("b2b_load_ready", 32'(ifa.KeyReadyxSO), 32'd1);
        ifa.StartxSI = 1'b0;
        wait_done_a(cyc);
        chk("b2b_latency2", 32'(cyc), 32'd178);
        ifa.KeyValidxSI = 1'b0;
        step();
        chk_idle_a("b2b_end");

        // NR=1 instance: single frame, Rcon never advances
        ifb.StartxSI = 1'b1; ifb.KeyValidxSI = 1'b1;
        cyc = 1;
        step(); cyc++;
        ifb.StartxSI = 1'b0;
        n_radd = 0; n_forth = 0;
        while (!ifb.DonexSO && cyc < 1000) begin
            if (ifb.RconAddxSO) n_radd++;
            if (ifb.ForthCyclexSO) n_forth++;
            if (ifb.RconAddxSO) chk("nr1_rcon_frame", 32'(ifb.RconxDO), 32'h01);
            step(); cyc++;
        end
        chk("nr1_latency",    32'(cyc),             32'd34);
        chk("nr1_radd_count", 32'(n_radd),          32'd1);
        chk("nr1_forth_cnt",  32'(n_forth),         32'd1);
        chk("nr1_done_rcon",  32'(ifb.RconxDO),     32'h01);
        chk("nr1_done_busy",  32'(ifb.BusyxSO),     32'd0);
        ifb.KeyValidxSI = 1'b0;
        step();
        chk("nr1_idle_done",  32'(ifb.DonexSO),     32'd0);
        chk("nr1_idle_rcon",  32'(ifb.RconxDO),     32'h01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
